imu_spi_responder: RTL and testbench
====================================

Name: imu_spi_responder

Overview:
- SPI slave (mode 0, MSB first) that models the MPU-6000-class IMU on the far end of the avionics board's IMU SPI master.
- Serves a 7-bit register map: live sensor bytes, a WHO_AM_I constant and writable configuration registers.
- Used as the bus-functional IMU in board-level simulation and in hardware-in-loop builds that replace the real sensor.
- All SPI inputs are asynchronous to clk and are synchronised internally.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on sck/ss/mosi before edge detection (≥2).
- WHO_AM_I_VAL, 8'h68, value returned at address 0x75.
- PWR_RST_VAL, 8'h40, reset value of PWR_MGMT_1 (0x6B).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sck  in  1  SPI clock from master (async)
- ss  in  1  SPI slave select, active low (async)
- mosi  in  1  master-out data (async)
- miso  out  1  slave-out data
- sensor_data  in  112  14 bytes; byte0 = [111:104] maps to 0x3B … byte13 = [7:0] maps to 0x48
- cfg_smplrt  out  8  reg 0x19
- cfg_config  out  8  reg 0x1A
- cfg_gyro  out  8  reg 0x1B
- cfg_accel  out  8  reg 0x1C
- cfg_pwr  out  8  reg 0x6B
- wr_strobe  out  1  one-cycle pulse per completed write byte, including unmapped addresses
- wr_addr  out  7  address of that write
- wr_data  out  8  data of that write
- busy  out  1  high while a transaction is active (ss low, synchronised)

Behaviour:
- Reset values:
  - miso = 0, busy = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0.
  - All cfg_* = 0 except cfg_pwr = PWR_RST_VAL.
  - FSM returns to IDLE.
  - Reset mid-transaction aborts it; the responder ignores the remainder until ss goes high and then low again.
- Synchronisation and edges:
  - sck, ss and mosi each pass through SYNC_STAGES flops, then one delay flop for edge detection.
  - Requirement on the master: sck high and low phases each ≥ SYNC_STAGES+2 clk cycles.
- FSM states: IDLE, ADDR, DATA, WAIT.
  - IDLE: on synchronised ss falling edge, go to ADDR; bit_cnt = 0; tx_sr = 0; latch sensor_data into snapshot register.
  - ADDR: shift mosi into rx_sr on each sck rising edge. On the 8th rising edge:
    - rw = rx bit7 (1 = read, 0 = write); addr = rx bits[6:0].
    - If read, tx_sr is loaded with read_data(addr); go to DATA.
  - DATA: 8-bit frames, bit_cnt wraps 7→0.
    - Read: on the 8th rising edge, addr = addr+1 and tx_sr is reloaded with read_data(addr+1).
    - Write: on the 8th rising edge, update the register at addr if it is writable; pulse wr_strobe with wr_addr/wr_data; addr = addr+1.
    - Address auto-increments and wraps 0x7F→0x00.
  - Any state: ss rising edge returns to IDLE next cycle; a partial byte is discarded (no strobe, no register update).
  - WAIT: entered on rst assertion while ss is low; exits to IDLE on ss high.
- MISO timing:
  - On each sck falling edge: miso = tx_sr[7]; tx_sr shifts left.
  - Consequently, during the address byte miso = 0, and read data bit7 appears on the 8th falling edge.
  - miso holds its value between edges and is driven to 0 in IDLE.
- Read map:
  - 0x3B..0x48: snapshot bytes, so a multi-byte burst is coherent to the ss-fall instant.
  - 0x19..0x1C and 0x6B: cfg values.
  - 0x75: WHO_AM_I_VAL.
  - All other addresses: 0x00.
- Write map:
  - Only 0x19..0x1C and 0x6B are writable; writes elsewhere are ignored except for wr_strobe.
  - A write to 0x6B with bit7 = 1 (DEVICE_RESET) restores all cfg_* to their reset values in place of storing the data.
- busy = synchronised ~ss, qualified by state != IDLE.

Decomposition:
- Shared package (imu_regs_pkg): register address constants (0x19, 0x1A, 0x1B, 0x1C, 0x3B, 0x48, 0x6B, 0x75), reset values, FSM state encodings, READ bit position.
- Sub-module: spi_slave_sync, holding the synchroniser and edge detector for sck/ss/mosi. It outputs sck_rise, sck_fall, ss_fall, ss_rise, ss_lvl and mosi_s.

Test Plan:
- Read WHO_AM_I: ss low, send 0xF5 then 0xFF, ss high → second byte on miso = 0x68; wr_strobe never pulses.
- Burst read: sensor_data = 0x0102…0E, send 0xBB plus 14 dummy bytes → miso bytes 0x01..0x0E. Changing sensor_data mid-burst does not alter the returned bytes.
- Write and readback: send 0x1C,0x18 → wr_strobe once with addr 0x1C / data 0x18 and cfg_accel = 0x18. A following read of 0x9C returns 0x18.
- Auto-increment wrap: write burst starting at 0x7F with data 0xAA,0x55 → strobes at 0x7F then 0x00; no cfg change.
- Abort: ss high after 4 bits of a write data byte to 0x19 → cfg_smplrt unchanged, no strobe, busy drops; the next transaction works normally.
- Reset and DEVICE_RESET: write 0x6B = 0x80 → all cfg_* at reset values (cfg_pwr = 0x40). Assert rst mid-read → miso = 0, state held in WAIT until ss high.

Source files
------------

// File: rtl/imu_spi_responder_pkg.sv
// Register map, reset values and FSM encoding shared by the IMU SPI responder
// and anything that needs to talk about its registers.
package imu_regs_pkg;

  localparam logic [6:0] ADDR_SMPLRT     = 7'h19;
  localparam logic [6:0] ADDR_CONFIG     = 7'h1A;
  localparam logic [6:0] ADDR_GYRO       = 7'h1B;
  localparam logic [6:0] ADDR_ACCEL      = 7'h1C;
  localparam logic [6:0] ADDR_SENS_FIRST = 7'h3B;
  localparam logic [6:0] ADDR_SENS_LAST  = 7'h48;
  localparam logic [6:0] ADDR_PWR        = 7'h6B;
  localparam logic [6:0] ADDR_WHO        = 7'h75;

  localparam logic [7:0] WHO_AM_I_DEFAULT = 8'h68;
  localparam logic [7:0] PWR_RST_DEFAULT  = 8'h40;

  localparam int READ_BIT      = 7;
  localparam int DEV_RESET_BIT = 7;
  localparam int SENSOR_BYTES  = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_WAIT = 2'd3
  } imu_state_e;

  function automatic logic is_sensor_addr(input logic [6:0] a);
    return (a >= ADDR_SENS_FIRST) && (a <= ADDR_SENS_LAST);
  endfunction

endpackage

// File: rtl/imu_spi_responder_if.sv
// SPI wires between the board's IMU master and the responder.
// Mode 0: master drives mosi/sck/ss, slave changes miso after sck falls and
// the master samples it on the next sck rise; ss is active low.
interface imu_spi_responder_if;
  logic sck;
  logic ss;
  logic mosi;
  logic miso;

  modport master (output sck, output ss, output mosi, input miso);
  modport slave  (input sck, input ss, input mosi, output miso);
endinterface

// File: rtl/imu_spi_responder_sync.sv
// Brings sck/ss/mosi into the clk domain and derives single-cycle edge pulses.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic sck,
  input  logic ss,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic ss_lvl,
  output logic mosi_s
);

  // No reset on purpose: the synchronised ss level must survive rst so the
  // FSM can tell whether a transaction is still in flight.
  logic [SYNC_STAGES-1:0] sck_q, sck_d;
  logic [SYNC_STAGES-1:0] ss_q, ss_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic sck_dly_q, sck_dly_d;
  logic ss_dly_q, ss_dly_d;
  logic mosi_dly_q, mosi_dly_d;

  always_comb begin
    sck_d      = {sck_q[SYNC_STAGES-2:0], sck};
    ss_d       = {ss_q[SYNC_STAGES-2:0], ss};
    mosi_d     = {mosi_q[SYNC_STAGES-2:0], mosi};
    sck_dly_d  = sck_q[SYNC_STAGES-1];
    ss_dly_d   = ss_q[SYNC_STAGES-1];
    mosi_dly_d = mosi_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    sck_q      <= sck_d;
    ss_q       <= ss_d;
    mosi_q     <= mosi_d;
    sck_dly_q  <= sck_dly_d;
    ss_dly_q   <= ss_dly_d;
    mosi_dly_q <= mosi_dly_d;
  end

  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_dly_q;
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_dly_q;
  assign ss_fall  = ~ss_q[SYNC_STAGES-1] & ss_dly_q;
  assign ss_rise  = ss_q[SYNC_STAGES-1] & ~ss_dly_q;
  assign ss_lvl   = ss_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_dly_q;

endmodule

// File: rtl/imu_spi_responder.sv
// Bus-functional MPU-6000-style IMU: SPI mode 0 slave with a 7-bit register
// map of sensor snapshot bytes, WHO_AM_I and writable configuration.
module imu_spi_responder
  import imu_regs_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] WHO_AM_I_VAL = WHO_AM_I_DEFAULT,
  parameter logic [7:0] PWR_RST_VAL  = PWR_RST_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  imu_spi_responder_if.slave        spi,
  input  logic [8*SENSOR_BYTES-1:0] sensor_data,
  output logic [7:0]                cfg_smplrt,
  output logic [7:0]                cfg_config,
  output logic [7:0]                cfg_gyro,
  output logic [7:0]                cfg_accel,
  output logic [7:0]                cfg_pwr,
  output logic                      wr_strobe,
  output logic [6:0]                wr_addr,
  output logic [7:0]                wr_data,
  output logic                      busy,
  output imu_state_e                state_dbg
);

  logic sck_rise, sck_fall, ss_fall, ss_rise, ss_lvl, mosi_s;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .sck      (spi.sck),
    .ss       (spi.ss),
    .mosi     (spi.mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_fall  (ss_fall),
    .ss_rise  (ss_rise),
    .ss_lvl   (ss_lvl),
    .mosi_s   (mosi_s)
  );

  imu_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [6:0] addr_q, addr_d;
  logic       rw_q, rw_d;
  logic [8*SENSOR_BYTES-1:0] snap_q, snap_d;
  logic [7:0] smplrt_q, smplrt_d, config_q, config_d, gyro_q, gyro_d;
  logic [7:0] accel_q, accel_d, pwr_q, pwr_d;
  logic       miso_q, miso_d, wr_strobe_q, wr_strobe_d, busy_q, busy_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [7:0] rx_next;
  logic       byte_done;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  assign rx_next   = {rx_sr_q, mosi_s};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7) && !ss_rise;

  // Reset while ss is low parks the FSM in WAIT so the tail of the aborted
  // transaction is ignored until the master releases ss.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ss_lvl ? ST_IDLE : ST_WAIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ss_fall) state_d = ST_ADDR;
      ST_ADDR: begin
        if (ss_rise)        state_d = ST_IDLE;
        else if (byte_done) state_d = ST_DATA;
      end
      ST_DATA: if (ss_rise) state_d = ST_IDLE;
      ST_WAIT: if (ss_lvl)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address whose contents get preloaded into tx_sr at the end of a byte.
  always_comb begin
    rd_addr = (state_q == ST_ADDR) ? rx_next[6:0] : addr_q + 7'd1;
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_SMPLRT: rd_data = smplrt_q;
      ADDR_CONFIG: rd_data = config_q;
      ADDR_GYRO:   rd_data = gyro_q;
      ADDR_ACCEL:  rd_data = accel_q;
      ADDR_PWR:    rd_data = pwr_q;
      ADDR_WHO:    rd_data = WHO_AM_I_VAL;
      default:     rd_data = 8'h00;
    endcase
    if (is_sensor_addr(rd_addr)) begin
      for (int k = 0; k < SENSOR_BYTES; k++) begin
        if (rd_addr == ADDR_SENS_FIRST + 7'(k)) rd_data = snap_q[8*(SENSOR_BYTES-1-k) +: 8];
      end
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    snap_d      = snap_q;
    smplrt_d    = smplrt_q;
    config_d    = config_q;
    gyro_d      = gyro_q;
    accel_d     = accel_q;
    pwr_d       = pwr_q;
    miso_d      = miso_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = ~ss_lvl && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          bit_cnt_d = 3'd0;
          rx_sr_d   = 7'd0;
          tx_sr_d   = 8'd0;
          snap_d    = sensor_data;
        end
      end
      ST_ADDR, ST_DATA: begin
        if (sck_fall && !ss_rise) begin
          miso_d  = tx_sr_q[7];
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end
        if (sck_rise && !ss_rise) begin
          rx_sr_d   = rx_next[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (byte_done && state_q == ST_ADDR) begin
          rw_d   = rx_next[READ_BIT];
          addr_d = rx_next[6:0];
          if (rx_next[READ_BIT]) tx_sr_d = rd_data;
        end else if (byte_done) begin
          addr_d = addr_q + 7'd1;
          if (rw_q) begin
            tx_sr_d = rd_data;
          end else begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = rx_next;
            if (addr_q == ADDR_PWR && rx_next[DEV_RESET_BIT]) begin
              smplrt_d = 8'h00;
              config_d = 8'h00;
              gyro_d   = 8'h00;
              accel_d  = 8'h00;
              pwr_d    = PWR_RST_VAL;
            end else begin
              case (addr_q)
                ADDR_SMPLRT: smplrt_d = rx_next;
                ADDR_CONFIG: config_d = rx_next;
                ADDR_GYRO:   gyro_d   = rx_next;
                ADDR_ACCEL:  accel_d  = rx_next;
                ADDR_PWR:    pwr_d    = rx_next;
                default:     ;
              endcase
            end
          end
        end
      end
      default: miso_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 7'd0;
      tx_sr_q     <= 8'd0;
      addr_q      <= 7'd0;
      rw_q        <= 1'b0;
      snap_q      <= '0;
      smplrt_q    <= 8'h00;
      config_q    <= 8'h00;
      gyro_q      <= 8'h00;
      accel_q     <= 8'h00;
      pwr_q       <= PWR_RST_VAL;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      snap_q      <= snap_d;
      smplrt_q    <= smplrt_d;
      config_q    <= config_d;
      gyro_q      <= gyro_d;
      accel_q     <= accel_d;
      pwr_q       <= pwr_d;
      miso_q      <= miso_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign spi.miso   = miso_q;
  assign cfg_smplrt = smplrt_q;
  assign cfg_config = config_q;
  assign cfg_gyro   = gyro_q;
  assign cfg_accel  = accel_q;
  assign cfg_pwr    = pwr_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_imu_spi_responder.sv
// Bench for imu_spi_responder: drives an SPI mode 0 master and compares
// against a register-map model of the IMU.
module tb_imu_spi_responder;
  import imu_regs_pkg::*;

  localparam int H = 6;  // sck half period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [111:0] sensor = '0;
  logic [7:0] cfg_smplrt, cfg_config, cfg_gyro, cfg_accel, cfg_pwr;
  logic wr_strobe, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  imu_state_e state_dbg;

  imu_spi_responder_if spi_if ();

  imu_spi_responder dut (
    .clk(clk), .rst(rst), .spi(spi_if.slave), .sensor_data(sensor),
    .cfg_smplrt(cfg_smplrt), .cfg_config(cfg_config), .cfg_gyro(cfg_gyro),
    .cfg_accel(cfg_accel), .cfg_pwr(cfg_pwr), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // reference model
  logic [7:0]   m_reg [128];
  logic [111:0] m_snap;
  logic [14:0]  exp_q[$];
  logic [7:0]   wr_q[$];

  function automatic logic m_writable(input logic [6:0] a);
    return a == 7'h19 || a == 7'h1A || a == 7'h1B || a == 7'h1C || a == 7'h6B;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 128; i++) m_reg[i] = 8'h00;
    m_reg[7'h6B] = 8'h40;
  endfunction

  function automatic logic [7:0] m_read(input logic [6:0] a);
    int k;
    k = int'(a) - 'h3B;
    if (k >= 0 && k < 14) return m_snap[(13 - k) * 8 +: 8];
    if (a == 7'h75) return 8'h68;
    if (m_writable(a)) return m_reg[a];
    return 8'h00;
  endfunction

  function automatic void m_write(input logic [6:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    if (a == 7'h6B && d[7]) m_reset();
    else if (m_writable(a)) m_reg[a] = d;
  endfunction

  // scoreboard for write strobes
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (exp_q.size() == 0) check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      else check("wr_strobe", {17'd0, wr_addr, wr_data}, {17'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_start();
    spi_if.ss = 1'b0;
    wait_clk(H);
  endtask

  task automatic spi_stop();
    wait_clk(H);
    spi_if.ss = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_if.mosi = tx[i];
      wait_clk(H);
      rx[i] = spi_if.miso;
      spi_if.sck = 1'b1;
      wait_clk(H);
      spi_if.sck = 1'b0;
    end
  endtask

  task automatic check_cfg(input string tag);
    check({tag, "_smplrt"}, {24'd0, cfg_smplrt}, {24'd0, m_reg[7'h19]});
    check({tag, "_config"}, {24'd0, cfg_config}, {24'd0, m_reg[7'h1A]});
    check({tag, "_gyro"},   {24'd0, cfg_gyro},   {24'd0, m_reg[7'h1B]});
    check({tag, "_accel"},  {24'd0, cfg_accel},  {24'd0, m_reg[7'h1C]});
    check({tag, "_pwr"},    {24'd0, cfg_pwr},    {24'd0, m_reg[7'h6B]});
  endtask

  task automatic random_sensor();
    for (int k = 0; k < 14; k++) sensor[8*k +: 8] = 8'($urandom);
  endtask

  // Full transaction; write data comes from wr_q when populated.
  task automatic do_txn(input logic rd, input logic [6:0] a0, input int n, input logic chg);
    logic [7:0] rx, d;
    logic [6:0] a;
    m_snap = sensor;
    spi_start();
    check("busy_active", 32'(busy), 32'd1);
    spi_bits({rd, a0}, 8, rx);
    check("miso_addr_byte", {24'd0, rx}, 32'd0);
    if (chg) random_sensor();
    a = a0;
    for (int i = 0; i < n; i++) begin
      if (rd) begin
        d = 8'($urandom);
        spi_bits(d, 8, rx);
        check("rd_data", {24'd0, rx}, {24'd0, m_read(a)});
      end else begin
        d = (wr_q.size() != 0) ? wr_q.pop_front() : 8'($urandom);
        m_write(a, d);
        spi_bits(d, 8, rx);
      end
      a = a + 7'd1;
    end
    spi_stop();
    check("busy_idle", 32'(busy), 32'd0);
    check("strobe_pending", 32'(exp_q.size()), 32'd0);
    check_cfg("cfg");
  endtask

  initial begin
    logic [7:0] rx;
    spi_if.sck = 1'b0;
    spi_if.ss = 1'b1;
    spi_if.mosi = 1'b0;
    m_reset();
    wait_clk(10);
    rst = 1'b0;
    wait_clk(2);

    // reset state
    check("rst_miso", 32'(spi_if.miso), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check_cfg("rst");

    // WHO_AM_I
    do_txn(1'b1, 7'h75, 1, 1'b0);

    // coherent burst of all sensor bytes, sensor changes after address byte
    for (int k = 0; k < 14; k++) sensor[(13 - k) * 8 +: 8] = 8'(k + 1);
    do_txn(1'b1, 7'h3B, 14, 1'b1);

    // write then read back
    wr_q.push_back(8'h18);
    do_txn(1'b0, 7'h1C, 1, 1'b0);
    check("accel_written", {24'd0, cfg_accel}, 32'h18);
    do_txn(1'b1, 7'h1C, 1, 1'b0);

    // address wrap 0x7F -> 0x00
    wr_q.push_back(8'hAA);
    wr_q.push_back(8'h55);
    do_txn(1'b0, 7'h7F, 2, 1'b0);

    // abort after 4 data bits
    spi_start();
    spi_bits({1'b0, 7'h19}, 8, rx);
    spi_bits(8'hC3, 4, rx);
    spi_stop();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_strobe", 32'(exp_q.size()), 32'd0);
    check_cfg("abort");
    wr_q.push_back(8'h07);
    do_txn(1'b0, 7'h19, 1, 1'b0);
    do_txn(1'b1, 7'h19, 4, 1'b0);

    // DEVICE_RESET
    wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33);
    do_txn(1'b0, 7'h1A, 3, 1'b0);
    wr_q.push_back(8'h80);
    do_txn(1'b0, 7'h6B, 1, 1'b0);
    check("devrst_pwr", {24'd0, cfg_pwr}, 32'h40);

    // rst in the middle of a read
    wr_q.push_back(8'h5A);
    do_txn(1'b0, 7'h1B, 1, 1'b0);
    spi_start();
    spi_bits(8'hF5, 8, rx);
    spi_bits(8'hFF, 3, rx);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    m_reset();
    wait_clk(1);
    check("midrst_miso", 32'(spi_if.miso), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(ST_WAIT));
    spi_bits(8'hFF, 5, rx);
    check("wait_rx_tail", {24'd0, rx}, 32'd0);
    spi_bits(8'h00, 8, rx);
    check("wait_rx_byte", {24'd0, rx}, 32'd0);
    check("wait_state", 32'(state_dbg), 32'(ST_WAIT));
    spi_stop();
    check("post_wait_state", 32'(state_dbg), 32'(ST_IDLE));
    check("post_wait_strobe", 32'(exp_q.size()), 32'd0);
    check_cfg("midrst");
    do_txn(1'b1, 7'h75, 2, 1'b0);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      logic [6:0] a;
      logic [6:0] wl[5];
      wl = '{7'h19, 7'h1A, 7'h1B, 7'h1C, 7'h6B};
      random_sensor();
      a = ($urandom_range(0, 2) == 0) ? wl[$urandom_range(0, 4)]
        : ($urandom_range(0, 1) == 0) ? 7'($urandom_range(8'h3B, 8'h48)) : 7'($urandom);
      do_txn(1'($urandom_range(0, 1)), a, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
